// File: rtl/frame_sequencer.sv
// frame_sequencer: 640x480 VGA raster with 2x2-replicated 320x240 ROM
// addressing and a tear-free START/PLAY/OVER frame source selector.
// Ports: i_clk, i_rst (async, active high); i_start, i_game_over,
// i_restart request pulses; o_frame_x/o_frame_y ROM address;
// i_start_rgb/i_game_rgb/i_over_rgb ROM data; o_rgb, o_hsync,
// o_vsync, o_de to the DAC; o_frame_end pulse and o_state status.
module frame_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ROM_LAT  = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_game_over,
  input  logic        i_restart,
  output logic [9:0]  o_frame_x,
  output logic [8:0]  o_frame_y,
  input  logic [23:0] i_start_rgb,
  input  logic [23:0] i_game_rgb,
  input  logic [23:0] i_over_rgb,
  output logic [23:0] o_rgb,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic        o_frame_end,
  output logic [1:0]  o_state
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    START = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_t;

  // Per-pixel control that travels alongside the ROM access.
  typedef struct packed {
    logic   de;
    logic   hs_n;
    logic   vs_n;
    state_t st;
  } pix_t;

  localparam int PW     = $bits(pix_t);
  localparam int PIPE_W = PW * (ROM_LAT + 1);
  localparam pix_t PIX_RST = '{
    de: 1'b0, hs_n: 1'b1, vs_n: 1'b1, st: START
  };

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       h_wrap;
  logic       boundary;

  state_t state;
  state_t state_nxt;
  logic   start_pend;
  logic   over_pend;
  logic   restart_pend;

  pix_t              s0;
  pix_t              tap;
  logic [PIPE_W-1:0] pipe;
  logic [23:0]       rgb_sel;

  // Stage 0: raster counters.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt  = v_cnt;
    if (h_wrap)
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
  end

  assign boundary = h_wrap && (v_cnt == V_LAST);

  // o_frame_end is decoded from the next count so the
  // registered pulse lines up with the boundary count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      o_frame_end <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      o_frame_end <= (h_nxt == H_LAST) && (v_nxt == V_LAST);
    end
  end

  // Frame source FSM: moves only on the last clock of a frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= START;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (boundary) begin
      unique case (state)
        START: if (start_pend | i_start)
                 state_nxt = PLAY;
        PLAY:  if (over_pend | i_game_over)
                 state_nxt = OVER;
        OVER:  if (restart_pend | i_restart)
                 state_nxt = START;
        default: state_nxt = START;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      start_pend   <= 1'b0;
      over_pend    <= 1'b0;
      restart_pend <= 1'b0;
    end else if (state_nxt != state) begin
      start_pend   <= 1'b0;
      over_pend    <= 1'b0;
      restart_pend <= 1'b0;
    end else begin
      if (state == START && i_start)
        start_pend <= 1'b1;
      if (state == PLAY && i_game_over)
        over_pend <= 1'b1;
      if (state == OVER && i_restart)
        restart_pend <= 1'b1;
    end
  end

  assign o_state = state;

  always_comb begin
    s0.de   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    s0.hs_n = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    s0.vs_n = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    s0.st   = state;
  end

  // Stage 1 coordinates plus a control shift register that is
  // 1+ROM_LAT deep; newest entry at the bottom, oldest at the top.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pipe      <= {(ROM_LAT + 1){PIX_RST}};
      o_frame_x <= '0;
      o_frame_y <= '0;
    end else begin
      pipe      <= PIPE_W'({pipe, s0});
      o_frame_x <= s0.de ? {1'b0, h_cnt[9:1]} : 10'd0;
      o_frame_y <= s0.de ? v_cnt[9:1] : 9'd0;
    end
  end

  assign tap = pix_t'(pipe[PIPE_W-1 -: PW]);

  always_comb begin
    rgb_sel = '0;
    if (tap.de) begin
      unique case (tap.st)
        START:   rgb_sel = i_start_rgb;
        PLAY:    rgb_sel = i_game_rgb;
        OVER:    rgb_sel = i_over_rgb;
        default: rgb_sel = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rgb   <= '0;
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
      o_de    <= 1'b0;
    end else begin
      o_rgb   <= rgb_sel;
      o_hsync <= tap.hs_n;
      o_vsync <= tap.vs_n;
      o_de    <= tap.de;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: randomized bench for frame_sequencer on a
// reduced raster, one DUT with ROM_LAT=0 and one with ROM_LAT=2.
module tb_frame_sequencer;

  localparam int HA  = 16;
  localparam int HFP = 4;
  localparam int HSW = 6;
  localparam int HBP = 6;
  localparam int VA  = 12;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic game_over = 1'b0;
  logic restart = 1'b0;
  logic [2:0] salt = 3'd0;

  logic [9:0]  x0, x2, xa, xb;
  logic [8:0]  y0, y2, ya, yb;
  logic [23:0] st_rgb0, gm_rgb0, ov_rgb0;
  logic [23:0] st_rgb2, gm_rgb2, ov_rgb2;
  logic [23:0] rgb0, rgb2;
  logic        hs0, vs0, de0, fe0;
  logic        hs2, vs2, de2, fe2;
  logic [1:0]  state0, state2;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 0;

  always #5 clk = ~clk;

  // ROM contents: source tag, run salt, row, column.
  function automatic logic [23:0] rom(input int s,
      input logic [2:0] sl, input logic [9:0] x,
      input logic [8:0] y);
    logic [1:0] tag;
    tag = 2'(s + 1);
    return {tag, sl, y, x};
  endfunction

  assign st_rgb0 = rom(0, salt, x0, y0);
  assign gm_rgb0 = rom(1, salt, x0, y0);
  assign ov_rgb0 = rom(2, salt, x0, y0);

  always @(posedge clk) begin
    xa <= x2; xb <= xa;
    ya <= y2; yb <= ya;
  end

  assign st_rgb2 = rom(0, salt, xb, yb);
  assign gm_rgb2 = rom(1, salt, xb, yb);
  assign ov_rgb2 = rom(2, salt, xb, yb);

  frame_sequencer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .ROM_LAT(0)
  ) u_lat0 (
    .i_clk(clk), .i_rst(rst),
    .i_start(start), .i_game_over(game_over),
    .i_restart(restart),
    .o_frame_x(x0), .o_frame_y(y0),
    .i_start_rgb(st_rgb0), .i_game_rgb(gm_rgb0),
    .i_over_rgb(ov_rgb0),
    .o_rgb(rgb0), .o_hsync(hs0), .o_vsync(vs0),
    .o_de(de0), .o_frame_end(fe0), .o_state(state0)
  );

  frame_sequencer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .ROM_LAT(2)
  ) u_lat2 (
    .i_clk(clk), .i_rst(rst),
    .i_start(start), .i_game_over(game_over),
    .i_restart(restart),
    .o_frame_x(x2), .o_frame_y(y2),
    .i_start_rgb(st_rgb2), .i_game_rgb(gm_rgb2),
    .i_over_rgb(ov_rgb2),
    .o_rgb(rgb2), .o_hsync(hs2), .o_vsync(vs2),
    .o_de(de2), .o_frame_end(fe2), .o_state(state2)
  );

  // Reference: k = clocks since reset release, ms = current
  // screen mode, mp = a valid request seen this frame,
  // fst[f] = mode shown during frame f.
  int k = 0;
  int ms = 0;
  bit mp = 0;
  int fst [256];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; ms = 0; mp = 0;
    end else begin
      if (k / FT < 256) fst[k / FT] = ms;
      if ((ms == 0 && start) || (ms == 1 && game_over) ||
          (ms == 2 && restart))
        mp = 1;
      if (k % FT == FT - 1) begin
        if (mp) ms = (ms + 1) % 3;
        mp = 0;
      end
      k = k + 1;
    end
  end

  // Expected {rgb, hsync, vsync, de} for a pin latency of 2+lat.
  function automatic logic [26:0] exp_pins(input int lat);
    int p, h, v, f;
    logic de, hs, vs;
    logic [23:0] rgb;
    p = k - 2 - lat;
    if (p < 0) return {24'h0, 3'b110};
    h = p % HT;
    v = (p / HT) % VT;
    f = p / FT;
    de = (h < HA) && (v < VA);
    hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    rgb = 24'h0;
    if (de)
      rgb = rom(fst[f < 256 ? f : 255], salt, 10'(h / 2), 9'(v / 2));
    return {rgb, hs, vs, de};
  endfunction

  function automatic logic [18:0] exp_xy();
    int p, h, v;
    p = k - 1;
    h = p % HT;
    v = (p / HT) % VT;
    if (p < 0 || h >= HA || v >= VA) return 19'h0;
    return {10'(h / 2), 9'(v / 2)};
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      logic [26:0] e0, e2;
      logic [18:0] exy;
      logic efe;
      e0 = exp_pins(0);
      e2 = exp_pins(2);
      exy = exp_xy();
      efe = (k % FT == FT - 1);
      n_vec += 5;
      if ({rgb0, hs0, vs0, de0} !== e0) begin
        n_err++;
        if (n_err <= 10)
          $display("FAIL pins_lat0 k=%0d got %h want %h",
                   k, {rgb0, hs0, vs0, de0}, e0);
      end
      if ({rgb2, hs2, vs2, de2} !== e2) begin
        n_err++;
        if (n_err <= 10)
          $display("FAIL pins_lat2 k=%0d got %h want %h",
                   k, {rgb2, hs2, vs2, de2}, e2);
      end
      if ({x0, y0} !== exy || {x2, y2} !== exy) begin
        n_err++;
        if (n_err <= 10)
          $display("FAIL coords k=%0d got %h/%h want %h",
                   k, {x0, y0}, {x2, y2}, exy);
      end
      if (fe0 !== efe || fe2 !== efe) begin
        n_err++;
        if (n_err <= 10)
          $display("FAIL frame_end k=%0d got %b/%b want %b",
                   k, fe0, fe2, efe);
      end
      if (state0 !== 2'(ms) || state2 !== 2'(ms)) begin
        n_err++;
        if (n_err <= 10)
          $display("FAIL state k=%0d got %0d/%0d want %0d",
                   k, state0, state2, ms);
      end
    end
  end

  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    while ((k % FT) != pos && n < 2 * FT) begin
      @(negedge clk);
      n++;
    end
    if ((k % FT) != pos) begin
      n_err++;
      $display("FAIL wait_pos timeout got %0d want %0d",
               k % FT, pos);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec += 2;
    if ({rgb0, hs0, vs0, de0, fe0, x0, y0, state0} !==
        {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 19'h0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_lat0 got %h %b%b%b%b %h %0d",
               rgb0, hs0, vs0, de0, fe0, {x0, y0}, state0);
    end
    if ({rgb2, hs2, vs2, de2, fe2, x2, y2, state2} !==
        {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 19'h0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_lat2 got %h %b%b%b%b %h %0d",
               rgb2, hs2, vs2, de2, fe2, {x2, y2}, state2);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    mon_en = 1;
  endtask

  task automatic test_timing();
    int hs_lo, vs_lo, de_hi, de_hi2, fe_n, run, max_run;
    int vrun, max_vrun;
    hs_lo = 0; vs_lo = 0; de_hi = 0; de_hi2 = 0; fe_n = 0;
    run = 0; max_run = 0; vrun = 0; max_vrun = 0;
    repeat (2 * FT) begin
      @(negedge clk);
      if (!hs0) hs_lo++;
      if (!vs0) vs_lo++;
      if (de0) de_hi++;
      if (de2) de_hi2++;
      if (fe0) fe_n++;
      run = hs0 ? 0 : run + 1;
      vrun = vs0 ? 0 : vrun + 1;
      if (run > max_run) max_run = run;
      if (vrun > max_vrun) max_vrun = vrun;
    end
    n_vec += 7;
    if (hs_lo !== 2 * VT * HSW) begin
      n_err++;
      $display("FAIL hsync_low got %0d want %0d", hs_lo, 2 * VT * HSW);
    end
    if (max_run !== HSW) begin
      n_err++;
      $display("FAIL hsync_width got %0d want %0d", max_run, HSW);
    end
    if (vs_lo !== 2 * VSW * HT) begin
      n_err++;
      $display("FAIL vsync_low got %0d want %0d", vs_lo, 2 * VSW * HT);
    end
    if (max_vrun !== VSW * HT) begin
      n_err++;
      $display("FAIL vsync_width got %0d want %0d", max_vrun, VSW * HT);
    end
    if (de_hi !== 2 * HA * VA) begin
      n_err++;
      $display("FAIL de_lat0 got %0d want %0d", de_hi, 2 * HA * VA);
    end
    if (de_hi2 !== 2 * HA * VA) begin
      n_err++;
      $display("FAIL de_lat2 got %0d want %0d", de_hi2, 2 * HA * VA);
    end
    if (fe_n !== 2) begin
      n_err++;
      $display("FAIL frame_end_count got %0d want 2", fe_n);
    end
  endtask

  task automatic test_coords();
    int th [5] = '{0, 1, 15, 28, 15};
    int tv [5] = '{11, 11, 11, 3, 0};
    int ex [5] = '{0, 0, 7, 0, 7};
    int ey [5] = '{5, 5, 5, 0, 0};
    for (int i = 0; i < 5; i++) begin
      wait_pos((tv[i] * HT + th[i] + 1) % FT);
      n_vec++;
      if (x0 !== 10'(ex[i]) || y0 !== 9'(ey[i]) ||
          x2 !== 10'(ex[i]) || y2 !== 9'(ey[i])) begin
        n_err++;
        $display("FAIL coord_map h=%0d v=%0d got %0d,%0d want %0d,%0d",
                 th[i], tv[i], x0, y0, ex[i], ey[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alignment();
    logic [23:0] want;
    want = rom(0, salt, 10'd0, 9'd0);
    wait_pos(1);
    n_vec++;
    if (de0 !== 1'b0 || rgb0 !== 24'h0) begin
      n_err++;
      $display("FAIL blank_lat0 got de=%b rgb=%h want de=0 rgb=0",
               de0, rgb0);
    end
    @(negedge clk);
    n_vec++;
    if (de0 !== 1'b1 || rgb0 !== want) begin
      n_err++;
      $display("FAIL first_px_lat0 got de=%b rgb=%h want de=1 rgb=%h",
               de0, rgb0, want);
    end
    @(negedge clk);
    n_vec++;
    if (de2 !== 1'b0 || rgb2 !== 24'h0) begin
      n_err++;
      $display("FAIL blank_lat2 got de=%b rgb=%h want de=0 rgb=0",
               de2, rgb2);
    end
    @(negedge clk);
    n_vec++;
    if (de2 !== 1'b1 || rgb2 !== want) begin
      n_err++;
      $display("FAIL first_px_lat2 got de=%b rgb=%h want de=1 rgb=%h",
               de2, rgb2, want);
    end
  endtask

  task automatic test_midframe_start();
    int bad, n;
    logic [23:0] want;
    wait_pos((VA / 2) * HT);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0; n = 0;
    while ((k % FT) != FT - 1 && n < 2 * FT) begin
      if (state0 !== 2'd0 || state2 !== 2'd0) bad++;
      @(negedge clk);
      n++;
    end
    if (state0 !== 2'd0 || state2 !== 2'd0) bad++;
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL early_switch got %0d cycles want 0", bad);
    end
    @(negedge clk);
    n_vec++;
    if (state0 !== 2'd1 || state2 !== 2'd1) begin
      n_err++;
      $display("FAIL start_to_play got %0d/%0d want 1",
               state0, state2);
    end
    want = rom(1, salt, 10'd0, 9'd0);
    wait_pos(2);
    n_vec++;
    if (rgb0 !== want) begin
      n_err++;
      $display("FAIL game_px_lat0 got %h want %h", rgb0, want);
    end
    wait_pos(4);
    n_vec++;
    if (rgb2 !== want) begin
      n_err++;
      $display("FAIL game_px_lat2 got %h want %h", rgb2, want);
    end
  endtask

  task automatic test_full_cycle();
    wait_pos(100);
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    wait_pos(0);
    n_vec++;
    if (state0 !== 2'd2) begin
      n_err++;
      $display("FAIL play_to_over got %0d want 2", state0);
    end
    wait_pos(50);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_pos(300);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_pos(0);
    n_vec++;
    if (state0 !== 2'd0) begin
      n_err++;
      $display("FAIL over_to_start got %0d want 0", state0);
    end
  endtask

  task automatic test_boundary();
    wait_pos(150);
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    wait_pos(0);
    n_vec++;
    if (state0 !== 2'd0) begin
      n_err++;
      $display("FAIL ignored_req got %0d want 0", state0);
    end
    wait_pos(FT - 1);
    n_vec++;
    if (state0 !== 2'd0) begin
      n_err++;
      $display("FAIL pre_boundary got %0d want 0", state0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (state0 !== 2'd1 || state2 !== 2'd1) begin
      n_err++;
      $display("FAIL boundary_start got %0d/%0d want 1",
               state0, state2);
    end
  endtask

  task automatic test_random();
    repeat (8 * FT) begin
      @(negedge clk);
      start     = ($urandom_range(0, 299) == 0);
      game_over = ($urandom_range(0, 299) == 0);
      restart   = ($urandom_range(0, 299) == 0);
      if (k % FT == 0) begin
        n_vec++;
        if (state0 !== 2'(ms)) begin
          n_err++;
          $display("FAIL random_state k=%0d got %0d want %0d",
                   k, state0, ms);
        end
      end
    end
    @(negedge clk);
    start = 1'b0; game_over = 1'b0; restart = 1'b0;
  endtask

  task automatic test_reset_mid();
    int f0, f2;
    for (int i = 0; i < 6 && ms != 1; i++) begin
      wait_pos(10);
      if (ms == 0) start = 1'b1;
      else restart = 1'b1;
      @(negedge clk);
      start = 1'b0; restart = 1'b0;
      wait_pos(0);
    end
    n_vec++;
    if (state0 !== 2'd1) begin
      n_err++;
      $display("FAIL pre_reset_play got %0d want 1", state0);
    end
    wait_pos(5 * HT + 10);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({rgb0, hs0, vs0, de0, fe0, x0, y0, state0,
         rgb2, hs2, vs2, de2, fe2, x2, y2, state2} !==
        {24'h0, 4'b1100, 19'h0, 2'd0,
         24'h0, 4'b1100, 19'h0, 2'd0}) begin
      n_err++;
      $display("FAIL mid_reset got %h %b%b%b%b %0d want 0 1100 0",
               rgb0, hs0, vs0, de0, fe0, state0);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    f0 = -1; f2 = -1;
    for (int n = 0; n < 3 * HT && (f0 < 0 || f2 < 0); n++) begin
      @(negedge clk);
      if (f0 < 0 && hs0 === 1'b0) f0 = k;
      if (f2 < 0 && hs2 === 1'b0) f2 = k;
    end
    n_vec += 2;
    if (f0 !== HA + HFP + 2) begin
      n_err++;
      $display("FAIL hsync_after_reset_lat0 got %0d want %0d",
               f0, HA + HFP + 2);
    end
    if (f2 !== HA + HFP + 4) begin
      n_err++;
      $display("FAIL hsync_after_reset_lat2 got %0d want %0d",
               f2, HA + HFP + 4);
    end
    wait_pos(FT - 1);
  endtask

  initial begin
    salt = 3'($urandom);
    test_reset();
    test_timing();
    test_coords();
    test_alignment();
    test_midframe_start();
    test_full_cycle();
    test_boundary();
    test_random();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Scans the 640x480 VGA raster and generates the 320x240 frame coordinates that feed the frame ROMs (start, game, game-over), using 2x2 pixel replication.
- Selects which frame source drives the screen through a 3-state FSM.
- State changes are applied only on frame boundaries, so a frame is never torn.
- Sits between the frame ROMs and the VGA DAC.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- ROM_LAT, 0, clocks from o_frame_x/o_frame_y to valid ROM rgb

Ports:
- i_clk  in  1  pixel clock (25 MHz)
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  one-cycle pulse, START -> PLAY request
- i_game_over  in  1  one-cycle pulse, PLAY -> OVER request
- i_restart  in  1  one-cycle pulse, OVER -> START request
- o_frame_x  out  10  ROM column, 0..319
- o_frame_y  out  9  ROM row, 0..239
- i_start_rgb  in  24  start-frame ROM data
- i_game_rgb  in  24  game-frame ROM data
- i_over_rgb  in  24  game-over ROM data
- o_rgb  out  24  pixel to DAC
- o_hsync  out  1  active-low
- o_vsync  out  1  active-low
- o_de  out  1  display enable
- o_frame_end  out  1  one-cycle pulse on the last clock of each frame
- o_state  out  2  0=START, 1=PLAY, 2=OVER

Behaviour:
- Reset (async, i_rst=1) sets:
  - h_cnt=0, v_cnt=0, state=START, all pending flags 0.
  - o_frame_x=0, o_frame_y=0, o_rgb=0, o_de=0, o_frame_end=0.
  - o_hsync=1, o_vsync=1, o_state=0.
- Counters:
  - h_cnt runs 0..H_TOT-1, with H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - v_cnt increments when h_cnt wraps; it runs 0..V_TOT-1, with V_TOT = 525.
  - Both wrap to 0.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- Sync windows:
  - hsync low while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync low on lines V_ACTIVE+V_FP .. V_ACTIVE+V_FP+V_SYNC-1.
- Coordinates (registered, stage 1):
  - In the active region, o_frame_x = h_cnt>>1 and o_frame_y = v_cnt>>1.
  - Otherwise both are 0.
- Pipeline and alignment:
  - Raster stage 0 (counters) -> stage 1 (coordinates) -> ROM_LAT stages -> output register.
  - hsync, vsync, de and the state-select signal are delayed through the same 1+ROM_LAT+1 stages.
  - o_rgb, o_hsync, o_vsync and o_de are therefore mutually aligned.
  - Total latency from counter to pins is 2+ROM_LAT clocks.
- o_rgb:
  - When delayed de=1, o_rgb is the source selected by the delayed state: START -> i_start_rgb, PLAY -> i_game_rgb, OVER -> i_over_rgb.
  - When delayed de=0, o_rgb = 0.
- Frame boundary: the cycle where h_cnt=H_TOT-1 and v_cnt=V_TOT-1. o_frame_end is registered and high for exactly that one cycle (it pulses at stage 0 timing).
- Request latching:
  - i_start is latched into start_pend only while state=START.
  - i_game_over is latched into over_pend only while state=PLAY.
  - i_restart is latched into restart_pend only while state=OVER.
  - A request arriving in any other state is ignored.
- FSM transitions (at the frame boundary only):
  - START -> PLAY if (start_pend | i_start).
  - PLAY -> OVER if (over_pend | i_game_over).
  - OVER -> START if (restart_pend | i_restart).
  - A pulse coinciding with the boundary cycle takes effect at that boundary.
  - All pending flags clear on any state change.
- At most one transition occurs per frame. A request in the new state must arrive at or after the clock following the transition.
- Repeated pulses before a boundary are idempotent.
- Reset mid-line or mid-frame: everything returns to the reset values immediately. Scanning restarts at h=0, v=0 on the first clock after deassertion.

Test Plan:
- Reset, release, run 2 frames with ROM_LAT=0:
  - o_hsync low for exactly 96 clocks every 800.
  - o_vsync low for exactly 1600 clocks every 420000.
  - o_de high for 640 clocks/line and 480 lines/frame.
  - o_frame_end pulses once per 420000 clocks.
- Coordinate map:
  - h_cnt=0/1 -> o_frame_x=0; h_cnt=639 -> 319; v_cnt=479 -> o_frame_y=239.
  - During blanking (h_cnt=700) both are 0.
- Alignment: drive i_start_rgb=24'hFF0000 and i_game_rgb=0.
  - The first o_de=1 clock shows FF0000.
  - o_rgb=0 whenever o_de=0.
  - Repeat with ROM_LAT=2 and confirm the same alignment.
- Pulse i_start mid-frame (v_cnt=100):
  - o_state stays 0 until the boundary, then becomes 1.
  - The next frame's first active pixel is i_game_rgb, with no mixed-source pixels in either frame.
- Pulse i_game_over while state=START (ignored, state stays 0). Then pulse i_start exactly on the boundary cycle.
  - State becomes PLAY at that boundary.
- Full cycle: START -> PLAY -> OVER -> START via the three pulses across three frames.
  - o_state goes 0 -> 1 -> 2 -> 0.
- Assert i_rst at h_cnt=300, v_cnt=50 while in PLAY:
  - All outputs take reset values immediately and o_state=0.
  - After release, the first hsync low edge occurs at clock 656+2.
